// File: rtl/keccak_pkg.sv
// Shared Keccak constants: slice geometry, z-counter width and the chi FSM state encoding.
package keccak_pkg;
   localparam int SLICE_W   = 25;
   localparam int SLICE_CNT = 64;
   localparam int CNT_W     = 6;

   typedef logic [SLICE_W-1:0] slice_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_READ   = 3'd1;
   localparam logic [2:0] ST_CHI    = 3'd2;
   localparam logic [2:0] ST_WRITE  = 3'd3;
   localparam logic [2:0] ST_CNT_UP = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_RUN    = 3'd6;
endpackage

// File: rtl/chi_slice.sv
// Combinational Keccak chi on one 25-bit slice; bit index is 5*y+x.
module chi_slice
   import keccak_pkg::*;
(
   input  logic [SLICE_W-1:0] i_slice,
   output logic [SLICE_W-1:0] o_slice
);

   always_comb begin
      o_slice = '0;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            o_slice[5*y+x] = i_slice[5*y+x] ^
                             (~i_slice[5*y+((x+1)%5)] & i_slice[5*y+((x+2)%5)]);
         end
      end
   end

endmodule

// File: rtl/chi_stage.sv
// Chi step over all 64 slices of the Keccak state held in external slice memory.
// Define CHI_STAGE_PIPELINE_EN for the single-state streaming variant (one slice per cycle).
module chi_stage
   import keccak_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               chi_en,
   output logic               mem_rd_en,
   output logic [CNT_W-1:0]   mem_rd_addr,
   input  logic [SLICE_W-1:0] mem_rdata,
   output logic               mem_wr_en,
   output logic [CNT_W-1:0]   mem_wr_addr,
   output logic [SLICE_W-1:0] mem_wdata,
   output logic               busy,
   output logic               done
);

   logic [2:0] r_state;
   logic [2:0] w_state_nxt;
   cnt_t       r_cnt;
   slice_t     r_res;
   slice_t     w_chi;
   logic       r_hold;
   logic       w_start;
   logic       w_carry;

   chi_slice u_chi (
      .i_slice (mem_rdata),
      .o_slice (w_chi)
   );

   // A request still high in Done must see one full Idle cycle before it restarts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_hold <= 1'b0;
      else      r_hold <= (r_state == ST_DONE);
   end

   assign w_start = (r_state == ST_IDLE) && chi_en && !r_hold;
   assign w_carry = (r_cnt == cnt_t'(SLICE_CNT-1));
   assign busy    = (r_state != ST_IDLE);
   assign done    = (r_state == ST_DONE);

`ifdef CHI_STAGE_PIPELINE_EN
   logic   r_rd_done;
   logic   r_vld_p1;
   cnt_t   r_addr_p1;
   logic   r_vld_p2;
   cnt_t   r_addr_p2;
   logic   w_rd;
   logic   w_last_wr;

   assign w_rd      = (r_state == ST_RUN) && !r_rd_done;
   assign w_last_wr = r_vld_p2 && (r_addr_p2 == cnt_t'(SLICE_CNT-1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last_wr) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_rd_done <= 1'b0;
         r_vld_p1  <= 1'b0;
         r_addr_p1 <= '0;
         r_vld_p2  <= 1'b0;
         r_addr_p2 <= '0;
         r_res     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE) begin
            r_cnt     <= '0;
            r_rd_done <= 1'b0;
         end else if (w_rd) begin
            r_cnt <= r_cnt + cnt_t'(1);
            if (w_carry) r_rd_done <= 1'b1;
         end
         // p1: read data returns from memory
         r_vld_p1  <= w_rd;
         r_addr_p1 <= w_rd ? r_cnt : '0;
         // p2: chi result registered, written back this cycle
         r_vld_p2  <= r_vld_p1;
         r_addr_p2 <= r_addr_p1;
         if (r_vld_p1) r_res <= w_chi;
      end
   end

   assign mem_rd_en   = w_rd;
   assign mem_rd_addr = w_rd ? r_cnt : '0;
   assign mem_wr_en   = (r_state == ST_RUN) && r_vld_p2;
   assign mem_wr_addr = mem_wr_en ? r_addr_p2 : '0;
   assign mem_wdata   = mem_wr_en ? r_res : '0;
`else
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_start) w_state_nxt = ST_READ;
         ST_READ:   w_state_nxt = ST_CHI;
         ST_CHI:    w_state_nxt = ST_WRITE;
         ST_WRITE:  w_state_nxt = ST_CNT_UP;
         ST_CNT_UP: w_state_nxt = w_carry ? ST_DONE : ST_READ;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_res   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE)        r_cnt <= '0;
         else if (r_state == ST_CNT_UP) r_cnt <= r_cnt + cnt_t'(1);
         if (r_state == ST_CHI) r_res <= w_chi;
      end
   end

   assign mem_rd_en   = (r_state == ST_READ);
   assign mem_rd_addr = mem_rd_en ? r_cnt : '0;
   assign mem_wr_en   = (r_state == ST_WRITE);
   assign mem_wr_addr = mem_wr_en ? r_cnt : '0;
   assign mem_wdata   = mem_wr_en ? r_res : '0;
`endif

endmodule

// File: tb/tb_chi_stage.sv
// Scoreboard bench for chi_stage: behavioural slice memory, expected-write queue, directed vectors.
module tb_chi_stage;

`ifdef CHI_STAGE_PIPELINE_EN
   localparam int DONE_CYC = 67;
   localparam int PERIOD   = 69;
   localparam int RST_CYC  = 40;
   localparam int RST_WR   = 38;
`else
   localparam int DONE_CYC = 257;
   localparam int PERIOD   = 259;
   localparam int RST_CYC  = 100;
   localparam int RST_WR   = 25;
`endif
   localparam int BOUND = 600;

   typedef struct packed {
      logic [5:0]  a;
      logic [24:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        chi_en;
   logic        mem_rd_en;
   logic [5:0]  mem_rd_addr;
   logic [24:0] mem_rdata;
   logic        mem_wr_en;
   logic [5:0]  mem_wr_addr;
   logic [24:0] mem_wdata;
   logic        busy;
   logic        done;

   logic [24:0] mem [64];
   logic [24:0] load_data [64];
   logic        load;
   wr_t         exp_q [$];
   int          errors = 0;
   int          checks = 0;
   int          wr_count = 0;

   chi_stage dut (
      .clk         (clk),
      .rst         (rst_n),
      .chi_en      (chi_en),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rdata   (mem_rdata),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wdata   (mem_wdata),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 64; i++) mem[i] <= load_data[i];
      end else if (mem_wr_en) begin
         mem[mem_wr_addr] <= mem_wdata;
      end
      mem_rdata <= mem_rd_en ? mem[mem_rd_addr] : 25'h0;
   end

   // Monitor: pops one expected write per observed strobe; also watches idle outputs.
   always @(negedge clk) begin
      if (mem_wr_en) begin
         wr_t e;
         checks++;
         wr_count++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_wr_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (mem_wr_addr !== e.a || mem_wdata !== e.d) begin
               errors++;
               $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                        mem_wr_addr, mem_wdata, e.a, e.d);
            end
         end
      end
      checks++;
      if ((!mem_wr_en && (mem_wr_addr !== 6'd0 || mem_wdata !== 25'd0)) ||
          (!mem_rd_en && mem_rd_addr !== 6'd0) ||
          (mem_rd_en && mem_wr_en && mem_rd_addr == mem_wr_addr)) begin
         errors++;
         $display("FAIL port_quiet: rd=%b/%0d wr=%b/%0d/%h, required zero when strobe low and no rd/wr same addr",
                  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wdata);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic fill(input logic [24:0] v);
      for (int i = 0; i < 64; i++) load_data[i] = v;
   endtask

   task automatic do_load();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic push_run();
      for (int i = 0; i < 64; i++) begin
         wr_t e;
         e.a = 6'(i);
         e.d = load_data[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(inout int n);
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < BOUND);
      if (!done) begin
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", BOUND);
      end
   endtask

   // Issue chi_en for the cycle where Idle samples it (cycle 0), then expect done at DONE_CYC.
   task automatic run_once(input string name);
      int n = 0;
      @(negedge clk);
      chi_en = 1'b1;
      @(posedge clk);
      #1 chi_en = 1'b0;
      wait_done(n);
      check({name, "_done_cycle"}, n, DONE_CYC);
      @(negedge clk);
      check({name, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
      check({name, "_queue_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int n;
      int n1;
      int base_wr;
      rst_n  = 1'b0;
      chi_en = 1'b0;
      load   = 1'b0;
      fill(25'h0);

      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr},
            32'd0);
      check("reset_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;

      // all-zero state
      fill(25'h0);
      do_load();
      push_run();
      run_once("zeros");

      // all-ones state
      fill(25'h1FFFFFF);
      do_load();
      push_run();
      run_once("ones");

      // sparse bits: row 0 bit 0, row 1 bit 1, row 4 bit 4
      fill(25'h0);
      load_data[5]  = 25'h0000001;
      load_data[10] = 25'h0000040;
      load_data[63] = 25'h1000000;
      do_load();
      push_run();
      exp_q[5].d  = 25'h0000009;
      exp_q[10].d = 25'h0000240;
      exp_q[63].d = 25'h1400000;
      run_once("bits");

      // reset mid-run
      fill(25'h1FFFFFF);
      do_load();
      push_run();
      @(negedge clk);
      chi_en = 1'b1;
      @(posedge clk);
      #1 chi_en = 1'b0;
      base_wr = wr_count;
      repeat (RST_CYC) @(negedge clk);
      #1 rst_n = 1'b0;
      check("rst_writes_before", wr_count - base_wr, RST_WR);
      exp_q.delete();
      @(posedge clk);
      #1;
      check("rst_outputs", {busy, done, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (300) begin
         @(negedge clk);
         if (done || busy) n++;
      end
      check("rst_no_done_no_busy", n, 0);

      // chi_en held high across two runs
      fill(25'h0);
      do_load();
      push_run();
      push_run();
      @(negedge clk);
      chi_en = 1'b1;
      @(posedge clk);
      n = 0;
      wait_done(n);
      check("held_first_done", n, DONE_CYC);
      n1 = n;
      @(negedge clk);
      n++;
      wait_done(n);
      chi_en = 1'b0;
      check("held_period", n - n1, PERIOD);
      repeat (4) @(negedge clk);
      check("held_stopped", busy, 0);
      check("held_queue_left", exp_q.size(), 0);

      // chi_en pulsed while busy and during Done
      fill(25'h0);
      do_load();
      push_run();
      @(negedge clk);
      chi_en = 1'b1;
      @(posedge clk);
      #1 chi_en = 1'b0;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         n++;
      end
      chi_en = 1'b1;
      @(negedge clk);
      n++;
      chi_en = 1'b0;
      wait_done(n);
      check("pulse_done_cycle", n, DONE_CYC);
      chi_en = 1'b1;
      @(negedge clk);
      chi_en = 1'b0;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy) n++;
      end
      check("pulse_no_restart", n, 0);
      check("pulse_queue_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
